// File: rtl/mult_rr_sched.sv
// Round-robin scheduler in front of a single sequential shift-add multiplier.
// Requesters are granted in rotating priority; the winner's operands are
// registered onto mul_a/mul_b, the multiplier is released from init, and the
// tagged product is returned on a one-cycle response strobe.
// Optional watchdog: define MULT_SCHED_TIMEOUT_EN to abort a WAIT that lasts
// TMO cycles with rsp_err=1 and a zero result.
//
// state  | meaning
// IDLE   | multiplier held in init, arbitrating the req vector
// LAUNCH | grant pulse to the winner, pointer advanced past it
// WAIT   | multiplier running; done ignored in the first cycle (stale level)
// RESP   | one-cycle response strobe, multiplier back in init
module mult_rr_sched #(
    parameter int W    = 3,
    parameter int NREQ = 4,
    parameter int IDW  = 2,
    parameter int TMO  = 64
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NREQ-1:0]     req,
    input  logic [NREQ*W-1:0]   a_in,
    input  logic [NREQ*W-1:0]   b_in,
    output logic [NREQ-1:0]     gnt,
    output logic                busy,
    output logic                rsp_valid,
    output logic [IDW-1:0]      rsp_id,
    output logic [2*W-1:0]      rsp_result,
    output logic                rsp_err,
    output logic [W-1:0]        mul_a,
    output logic [W-1:0]        mul_b,
    output logic                mul_init,
    input  logic                mul_done,
    input  logic [2*W-1:0]      mul_result
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LAUNCH = 2'd1,
        S_WAIT   = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [IDW-1:0]  ptr;
    logic [IDW-1:0]  cur_id;
    logic [IDW-1:0]  win_id;
    logic            win_found;
    logic [IDW:0]    scan_pos;
    logic            wait_first;
    logic            done_acc;
    logic            tmo_hit;
    logic [2*W-1:0]  res_q;

    assign done_acc = (state == S_WAIT) && !wait_first && mul_done;

`ifdef MULT_SCHED_TIMEOUT_EN
    localparam int CW = $clog2(TMO + 1);
    logic [CW-1:0] tmo_cnt;
    logic          err_q;

    assign tmo_hit = (state == S_WAIT) && !done_acc && (tmo_cnt == CW'(TMO - 1));
    assign rsp_err = err_q;

    // Watchdog: counts WAIT cycles, cleared while launching a new operation
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt <= '0;
            err_q   <= 1'b0;
        end else begin
            if (state == S_LAUNCH) begin
                tmo_cnt <= '0;
            end else if (state == S_WAIT) begin
                tmo_cnt <= tmo_cnt + 1'b1;
                if (done_acc) begin
                    err_q <= 1'b0;
                end else if (tmo_hit) begin
                    err_q <= 1'b1;
                end
            end
        end
    end
`else
    assign tmo_hit = 1'b0;
    assign rsp_err = 1'b0;
`endif

    assign rsp_id     = cur_id;
    assign rsp_result = res_q;

    // Rotating-priority search: first set req bit at or after ptr, wrapping
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        scan_pos  = '0;
        for (int i = 0; i < NREQ; i++) begin
            scan_pos = {1'b0, ptr} + (IDW+1)'(i);
            if (scan_pos >= (IDW+1)'(NREQ)) begin
                scan_pos = scan_pos - (IDW+1)'(NREQ);
            end
            if (!win_found && req[scan_pos[IDW-1:0]]) begin
                win_found = 1'b1;
                win_id    = scan_pos[IDW-1:0];
            end
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and state-decoded outputs
    always_comb begin
        state_nxt = state;
        gnt       = '0;
        busy      = 1'b1;
        rsp_valid = 1'b0;
        mul_init  = 1'b1;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (win_found) begin
                    state_nxt = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                gnt       = NREQ'(1) << cur_id;
                state_nxt = S_WAIT;
            end
            S_WAIT: begin
                mul_init = 1'b0;
                if (done_acc || tmo_hit) begin
                    state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                rsp_valid = 1'b1;
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Operand capture, pointer update and product latch
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr        <= '0;
            cur_id     <= '0;
            mul_a      <= '0;
            mul_b      <= '0;
            res_q      <= '0;
            wait_first <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (win_found) begin
                        cur_id <= win_id;
                        mul_a  <= a_in[win_id*W +: W];
                        mul_b  <= b_in[win_id*W +: W];
                    end
                end
                S_LAUNCH: begin
                    ptr        <= (cur_id == IDW'(NREQ - 1)) ? '0 : cur_id + 1'b1;
                    wait_first <= 1'b1;
                end
                S_WAIT: begin
                    wait_first <= 1'b0;
                    if (done_acc) begin
                        res_q <= mul_result;
                    end else if (tmo_hit) begin
                        res_q <= '0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_rr_sched.sv
// Bench for mult_rr_sched: a stand-in multiplier, a transaction-level model
// (grant/response timestamps) checked every cycle, and directed scenarios
// with literal expectations.
module tb_mult_rr_sched;

    localparam int W    = 3;
    localparam int NREQ = 4;
    localparam int IDW  = 2;
    localparam int TMO  = 64;
    localparam int INF  = 32'h7fff_ffff;

    logic                clk;
    logic                rst_n;
    logic [NREQ-1:0]     req;
    logic [NREQ*W-1:0]   a_in;
    logic [NREQ*W-1:0]   b_in;
    logic [NREQ-1:0]     gnt;
    logic                busy;
    logic                rsp_valid;
    logic [IDW-1:0]      rsp_id;
    logic [2*W-1:0]      rsp_result;
    logic                rsp_err;
    logic [W-1:0]        mul_a;
    logic [W-1:0]        mul_b;
    logic                mul_init;
    logic                mul_done;
    logic [2*W-1:0]      mul_result;

    mult_rr_sched #(.W(W), .NREQ(NREQ), .IDW(IDW), .TMO(TMO)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .a_in       (a_in),
        .b_in       (b_in),
        .gnt        (gnt),
        .busy       (busy),
        .rsp_valid  (rsp_valid),
        .rsp_id     (rsp_id),
        .rsp_result (rsp_result),
        .rsp_err    (rsp_err),
        .mul_a      (mul_a),
        .mul_b      (mul_b),
        .mul_init   (mul_init),
        .mul_done   (mul_done),
        .mul_result (mul_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int gnt_seen = 0;
    int rsp_seen = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- stand-in multiplier ----------------
    int   mul_lat  = 2;
    bit   mul_hang = 1'b0;
    bit   stale_en = 1'b0;
    logic mdone;
    logic init_d;
    logic stale;
    int   mcnt;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mdone  <= 1'b0;
            mcnt   <= 0;
            init_d <= 1'b1;
        end else begin
            init_d <= mul_init;
            if (mul_init) begin
                mdone <= 1'b0;
                mcnt  <= 0;
            end else if (!mul_hang) begin
                if (mcnt >= mul_lat) mdone <= 1'b1;
                else                 mcnt  <= mcnt + 1;
            end
        end
    end

    // Optional bogus done pulse in the first cycle the multiplier is released
    assign stale      = stale_en && !mul_init && init_d;
    assign mul_done   = mdone || stale;
    assign mul_result = stale ? 6'h3F : ((2*W)'(mul_a) * (2*W)'(mul_b));

    // ---------------- transaction model ----------------
    int             cyc = 0;
    bit             m_active = 1'b0;
    int             m_ptr = 0;
    int             m_id = 0;
    logic [W-1:0]   m_a, m_b;
    logic [2*W-1:0] m_res;
    bit             m_err;
    int             t_gnt, t_w, t_resp;

    function automatic int rr_pick(input logic [NREQ-1:0] r, input int p);
        for (int i = 0; i < NREQ; i++) begin
            if (r[(p + i) % NREQ]) return (p + i) % NREQ;
        end
        return -1;
    endfunction

    // A request seen in a free cycle c is granted in c+1, the multiplier runs
    // from c+2, done counts from c+3, the response follows acceptance by one
    // cycle and the scheduler is free again the cycle after the response.
    always @(posedge clk) begin
        if (!rst_n) begin
            m_active = 1'b0;
            m_ptr    = 0;
        end else if (m_active && cyc == t_resp) begin
            m_active = 1'b0;
        end else if (!m_active && |req) begin
            m_id     = rr_pick(req, m_ptr);
            m_a      = a_in[m_id*W +: W];
            m_b      = b_in[m_id*W +: W];
            t_gnt    = cyc + 1;
            t_w      = cyc + 2;
            t_resp   = INF;
            m_ptr    = (m_id + 1) % NREQ;
            m_active = 1'b1;
        end else if (m_active && t_resp == INF) begin
            if (cyc >= t_w + 1 && mul_done === 1'b1) begin
                t_resp = cyc + 1;
                m_res  = (2*W)'(m_a) * (2*W)'(m_b);
                m_err  = 1'b0;
            end
`ifdef MULT_SCHED_TIMEOUT_EN
            else if (cyc == t_w + TMO - 1) begin
                t_resp = cyc + 1;
                m_res  = '0;
                m_err  = 1'b1;
            end
`endif
        end
        cyc++;
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        logic [NREQ-1:0] e_gnt;
        logic            e_busy, e_init, e_valid;
        if (cyc > 0) begin
            e_gnt   = '0;
            e_busy  = 1'b0;
            e_init  = 1'b1;
            e_valid = 1'b0;
            if (rst_n && m_active) begin
                if (cyc == t_gnt) e_gnt = NREQ'(1) << m_id;
                e_busy  = (cyc >= t_gnt) && (cyc <= t_resp);
                e_init  = !((cyc >= t_w) && (cyc < t_resp));
                e_valid = (cyc == t_resp);
            end
            chk("gnt", 32'(gnt), 32'(e_gnt));
            chk("busy", 32'(busy), 32'(e_busy));
            chk("mul_init", 32'(mul_init), 32'(e_init));
            chk("rsp_valid", 32'(rsp_valid), 32'(e_valid));
            if (e_valid) begin
                chk("rsp_id", 32'(rsp_id), 32'(m_id));
                chk("rsp_result", 32'(rsp_result), 32'(m_res));
                chk("rsp_err", 32'(rsp_err), 32'(m_err));
            end
            if (rst_n && m_active && cyc >= t_gnt) begin
                chk("mul_a", 32'(mul_a), 32'(m_a));
                chk("mul_b", 32'(mul_b), 32'(m_b));
            end
            if (gnt != '0) gnt_seen++;
            if (rsp_valid) rsp_seen++;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic wait_gnt(output int id);
        id = -1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (gnt != '0) begin
                for (int k = 0; k < NREQ; k++) if (gnt[k]) id = k;
                return;
            end
        end
        n_checks++;
        n_errors++;
        $display("FAIL wait_gnt: no grant within 60 cycles");
    endtask

    task automatic wait_rsp(input int lim, output bit got);
        got = 1'b0;
        for (int i = 0; i < lim; i++) begin
            @(negedge clk);
            if (rsp_valid) begin
                got = 1'b1;
                return;
            end
        end
        n_checks++;
        n_errors++;
        $display("FAIL wait_rsp: no response within %0d cycles", lim);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b1;
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        int id;
        bit got;
        int g_cyc;
        int rs_before;
        int ids[5];
        int res[5];
        int exp_ids[5];
        int exp_res[5];
        int c_id[3];
        int c_a[3];
        int c_b[3];
        int c_p[3];

        rst_n = 1'b0;
        req   = '0;
        a_in  = '0;
        b_in  = '0;
        repeat (3) @(negedge clk);
        #1;
        chk("reset_busy", 32'(busy), 0);
        chk("reset_mul_init", 32'(mul_init), 1);
        chk("reset_gnt", 32'(gnt), 0);
        chk("reset_mul_a", 32'(mul_a), 0);
        chk("reset_rsp_result", 32'(rsp_result), 0);
        #1 rst_n = 1'b1;

        // single request: 3 x 5
        @(negedge clk);
        a_in[0 +: W] = 3'd3;
        b_in[0 +: W] = 3'd5;
        req = 4'b0001;
        @(negedge clk);
        chk("t1_gnt", 32'(gnt), 32'h1);
        req = '0;
        wait_rsp(40, got);
        if (got) begin
            chk("t1_id", 32'(rsp_id), 0);
            chk("t1_result", 32'(rsp_result), 15);
            chk("t1_err", 32'(rsp_err), 0);
        end

        // contention with all requests held, stale done pulse present
        do_reset();
        stale_en = 1'b1;
        mul_lat  = 1;
        for (int k = 0; k < NREQ; k++) begin
            a_in[k*W +: W] = 3'(k + 1);
            b_in[k*W +: W] = 3'd2;
        end
        req = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            wait_gnt(ids[g]);
            if (g == 4) req = '0;
            wait_rsp(40, got);
            res[g] = got ? int'(rsp_result) : -1;
        end
        exp_ids = '{0, 1, 2, 3, 0};
        exp_res = '{2, 4, 6, 8, 2};
        for (int g = 0; g < 5; g++) begin
            chk($sformatf("t2_grant%0d", g), 32'(ids[g]), 32'(exp_ids[g]));
            chk($sformatf("t2_result%0d", g), 32'(res[g]), 32'(exp_res[g]));
        end
        stale_en = 1'b0;

        // operand corners, fastest multiplier
        mul_lat = 0;
        c_id = '{1, 2, 3};
        c_a  = '{7, 5, 0};
        c_b  = '{7, 0, 6};
        c_p  = '{49, 0, 0};
        for (int v = 0; v < 3; v++) begin
            @(negedge clk);
            a_in[c_id[v]*W +: W] = 3'(c_a[v]);
            b_in[c_id[v]*W +: W] = 3'(c_b[v]);
            req = NREQ'(1) << c_id[v];
            wait_gnt(id);
            chk($sformatf("t3_gnt%0d", v), 32'(id), 32'(c_id[v]));
            req = '0;
            wait_rsp(40, got);
            if (got) chk($sformatf("t3_result%0d", v), 32'(rsp_result), 32'(c_p[v]));
        end
        repeat (3) @(negedge clk);
        chk("t3_one_rsp_per_gnt", 32'(rsp_seen), 32'(gnt_seen));

        // fairness: grant 2, then 0101 -> 0 then 2
        do_reset();
        mul_lat = 2;
        for (int k = 0; k < NREQ; k++) begin
            a_in[k*W +: W] = 3'd1;
            b_in[k*W +: W] = 3'd1;
        end
        req = 4'b0100;
        wait_gnt(id);
        chk("t4_first", 32'(id), 2);
        req = '0;
        wait_rsp(40, got);
        req = 4'b0101;
        wait_gnt(id);
        chk("t4_second", 32'(id), 0);
        wait_rsp(40, got);
        wait_gnt(id);
        chk("t4_third", 32'(id), 2);
        req = '0;
        wait_rsp(40, got);

        // reset while waiting on the multiplier
        mul_hang = 1'b1;
        a_in[1*W +: W] = 3'd3;
        b_in[1*W +: W] = 3'd3;
        req = 4'b0010;
        wait_gnt(id);
        req = '0;
        repeat (3) @(negedge clk);
        chk("t5_in_wait", 32'(mul_init), 0);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_busy", 32'(busy), 0);
        chk("t5_mul_init", 32'(mul_init), 1);
        chk("t5_rsp_valid", 32'(rsp_valid), 0);
        chk("t5_mul_a", 32'(mul_a), 0);
        chk("t5_mul_b", 32'(mul_b), 0);
        chk("t5_rsp_result", 32'(rsp_result), 0);
        chk("t5_rsp_id", 32'(rsp_id), 0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        mul_hang = 1'b0;
        rs_before = rsp_seen;
        repeat (8) @(negedge clk);
        chk("t5_no_rsp", 32'(rsp_seen), 32'(rs_before));
        req = 4'b1111;
        wait_gnt(id);
        chk("t5_ptr_reset", 32'(id), 0);
        req = '0;
        wait_rsp(40, got);

        // multiplier never finishes
        mul_hang = 1'b1;
        a_in[3*W +: W] = 3'd2;
        b_in[3*W +: W] = 3'd3;
        req = 4'b1000;
        wait_gnt(id);
        g_cyc = cyc;
        req = '0;
`ifdef MULT_SCHED_TIMEOUT_EN
        wait_rsp(120, got);
        if (got) begin
            chk("t6_latency", 32'(cyc - g_cyc), 32'(TMO + 1));
            chk("t6_err", 32'(rsp_err), 1);
            chk("t6_result", 32'(rsp_result), 0);
            chk("t6_id", 32'(rsp_id), 3);
        end
        mul_hang = 1'b0;
`else
        rs_before = rsp_seen;
        repeat (100) @(negedge clk);
        chk("t6_busy_held", 32'(busy), 1);
        chk("t6_no_rsp", 32'(rsp_seen), 32'(rs_before));
        do_reset();
        mul_hang = 1'b0;
`endif
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
